nf10_entropy_filter: RTL and testbench



---
 rtl/nf10_entropy_filter_pkg.sv | 14 +
 rtl/nf10_axis_reg_slice.sv | 43 ++++
 rtl/nf10_entropy_filter.sv | 137 +++++++++++++
 tb/tb_nf10_entropy_filter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_entropy_filter_pkg.sv
// rtl/nf10_entropy_filter_pkg.sv - shared types and constants for the entropy filter
package nf10_entropy_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int SCORE_LSB   = 32;
    localparam int SCORE_WIDTH = 16;
    localparam int CNT_WIDTH   = 32;

endpackage

// File: rtl/nf10_axis_reg_slice.sv
// rtl/nf10_axis_reg_slice.sv - single-stage registered AXI-Stream output slice
module nf10_axis_reg_slice #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tstrb,
    input  logic [USER_WIDTH-1:0]   s_tuser,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tstrb,
    output logic [USER_WIDTH-1:0]   m_tuser,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready
);

    assign s_tready = !m_tvalid | m_tready;

    // Payload only loads on a real beat so a drained register keeps its last contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tstrb  <= '0;
            m_tuser  <= '0;
            m_tlast  <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
                m_tstrb <= s_tstrb;
                m_tuser <= s_tuser;
                m_tlast <= s_tlast;
            end
        end
    end

endmodule

// File: rtl/nf10_entropy_filter.sv
// rtl/nf10_entropy_filter.sv - per-packet entropy score filter; NF10_ENTROPY_FILTER_STATS_EN enables counters
import nf10_entropy_filter_pkg::*;

module nf10_entropy_filter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_SCORE_LSB          = SCORE_LSB,
    parameter int C_SCORE_WIDTH        = SCORE_WIDTH
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              filter_en,
    input  logic [C_SCORE_WIDTH-1:0]          threshold,
    input  logic                              clear_cnt,
    output logic [CNT_WIDTH-1:0]              pkt_pass_cnt,
    output logic [CNT_WIDTH-1:0]              pkt_drop_cnt
);

    state_t                   state;
    logic [C_SCORE_WIDTH-1:0] score;
    logic                     drop_dec;
    logic                     fwd;
    logic                     slice_ready;
    logic                     s_fire;
    logic                     first_fire;

    assign score    = s_axis_tuser[C_SCORE_LSB +: C_SCORE_WIDTH];
    assign drop_dec = filter_en & (score > threshold);

    // Drop paths never wait on the output register, so they absorb beats under backpressure.
    always_comb begin
        fwd           = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE: begin
                fwd           = !drop_dec;
                s_axis_tready = drop_dec | slice_ready;
            end
            ST_PASS: begin
                fwd           = 1'b1;
                s_axis_tready = slice_ready;
            end
            ST_DROP: begin
                fwd           = 1'b0;
                s_axis_tready = 1'b1;
            end
            default: begin
                fwd           = 1'b0;
                s_axis_tready = 1'b0;
            end
        endcase
        if (axi_reset) begin
            s_axis_tready = 1'b0;
        end
    end

    assign s_fire     = s_axis_tvalid & s_axis_tready;
    assign first_fire = s_fire & (state == ST_IDLE);

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state <= ST_IDLE;
        end else if (s_fire) begin
            if (state == ST_IDLE) begin
                if (!s_axis_tlast) begin
                    state <= drop_dec ? ST_DROP : ST_PASS;
                end
            end else if (s_axis_tlast) begin
                state <= ST_IDLE;
            end
        end
    end

    nf10_axis_reg_slice #(
        .DATA_WIDTH (C_M_AXIS_DATA_WIDTH),
        .USER_WIDTH (C_M_AXIS_TUSER_WIDTH)
    ) u_out_slice (
        .clk      (axi_aclk),
        .rst      (axi_reset),
        .s_tdata  (s_axis_tdata),
        .s_tstrb  (s_axis_tstrb),
        .s_tuser  (s_axis_tuser),
        .s_tlast  (s_axis_tlast),
        .s_tvalid (s_fire & fwd),
        .s_tready (slice_ready),
        .m_tdata  (m_axis_tdata),
        .m_tstrb  (m_axis_tstrb),
        .m_tuser  (m_axis_tuser),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

`ifdef NF10_ENTROPY_FILTER_STATS_EN
    logic [CNT_WIDTH-1:0] pass_cnt_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else if (clear_cnt) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else if (first_fire) begin
            if (drop_dec) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end else begin
                pass_cnt_q <= pass_cnt_q + 1'b1;
            end
        end
    end

    assign pkt_pass_cnt = pass_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = clear_cnt | first_fire;
    assign pkt_pass_cnt = '0;
    assign pkt_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_nf10_entropy_filter.sv
// tb/tb_nf10_entropy_filter.sv - randomized self-checking bench against a packet-level model
module tb_nf10_entropy_filter;

    logic         axi_aclk = 1'b0;
    logic         axi_reset = 1'b1;
    logic [255:0] s_axis_tdata = '0;
    logic [31:0]  s_axis_tstrb = '0;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;
    logic         filter_en = 1'b1;
    logic [15:0]  threshold = 16'h8000;
    logic         clear_cnt = 1'b0;
    logic [31:0]  pkt_pass_cnt;
    logic [31:0]  pkt_drop_cnt;

    nf10_entropy_filter dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .filter_en     (filter_en),
        .threshold     (threshold),
        .clear_cnt     (clear_cnt),
        .pkt_pass_cnt  (pkt_pass_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    int          tests = 0;
    int          fails = 0;
    beat_t       expq[$];
    bit          in_pkt = 0;
    bit          pkt_drop = 0;
    int unsigned mdl_pass = 0;
    int unsigned mdl_drop = 0;
    int          outs = 0;
    bit          rdy_rand = 0;

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge axi_aclk) begin
        #1;
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Packet-level reference: expected output is the queue of forwarded beats not yet taken.
    always @(negedge axi_aclk) begin
        bit    first;
        bit    dec_drop;
        bit    exp_rdy;
        beat_t cur;
        if (axi_reset) begin
            check(m_axis_tvalid == 1'b0, "rst_mvalid", m_axis_tvalid, 0);
            check(s_axis_tready == 1'b0, "rst_sready", s_axis_tready, 0);
            check(m_axis_tdata == '0 && m_axis_tuser == '0 && m_axis_tstrb == '0 && !m_axis_tlast,
                  "rst_mdata", m_axis_tdata, 0);
            check(pkt_pass_cnt == 0 && pkt_drop_cnt == 0, "rst_cnt", {pkt_pass_cnt, pkt_drop_cnt}, 0);
            expq.delete();
            in_pkt   = 0;
            mdl_pass = 0;
            mdl_drop = 0;
        end else begin
            first    = !in_pkt;
            dec_drop = first ? (filter_en && (s_axis_tuser[32 +: 16] > threshold)) : pkt_drop;
            exp_rdy  = dec_drop ? 1'b1 : (expq.size() == 0 || m_axis_tready);
            check(s_axis_tready == exp_rdy, "s_ready", s_axis_tready, exp_rdy);
            check(m_axis_tvalid == (expq.size() != 0), "m_valid", m_axis_tvalid, expq.size() != 0);
            if (expq.size() != 0) begin
                check(m_axis_tdata == expq[0].d, "m_tdata", m_axis_tdata, expq[0].d);
                check(m_axis_tstrb == expq[0].s && m_axis_tuser == expq[0].u && m_axis_tlast == expq[0].l,
                      "m_side", {m_axis_tlast, m_axis_tstrb, m_axis_tuser}, {expq[0].l, expq[0].s, expq[0].u});
            end
`ifdef NF10_ENTROPY_FILTER_STATS_EN
            check(pkt_pass_cnt == mdl_pass, "pass_cnt", pkt_pass_cnt, mdl_pass);
            check(pkt_drop_cnt == mdl_drop, "drop_cnt", pkt_drop_cnt, mdl_drop);
`else
            check(pkt_pass_cnt == 0 && pkt_drop_cnt == 0, "cnt_tied", {pkt_pass_cnt, pkt_drop_cnt}, 0);
`endif
            if (m_axis_tvalid && m_axis_tready && expq.size() != 0) begin
                void'(expq.pop_front());
                outs++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                cur.d = s_axis_tdata;
                cur.s = s_axis_tstrb;
                cur.u = s_axis_tuser;
                cur.l = s_axis_tlast;
                if (!dec_drop) expq.push_back(cur);
                if (first) begin
                    if (dec_drop) mdl_drop++;
                    else mdl_pass++;
                    pkt_drop = dec_drop;
                    in_pkt   = !s_axis_tlast;
                end else if (s_axis_tlast) begin
                    in_pkt = 0;
                end
            end
            if (clear_cnt) begin
                mdl_pass = 0;
                mdl_drop = 0;
            end
        end
    end

    task automatic send_beat(input logic [15:0] score, input bit last);
        int n = 0;
        logic [255:0] d;
        logic [127:0] u;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) u[i*32 +: 32] = $urandom;
        u[32 +: 16]   = score;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tstrb  = $urandom;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge axi_aclk);
            n++;
        end while (!s_axis_tready && n < 200);
        if (n >= 200) check(0, "accept_timeout", 0, 1);
        @(posedge axi_aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nbeats, input logic [15:0] score, input int gap_max);
        for (int b = 0; b < nbeats; b++) begin
            send_beat((b == 0) ? score : 16'($urandom), b == nbeats - 1);
            repeat ($urandom_range(0, gap_max)) @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    initial begin
        int o0;
        int unsigned p0, d0;
        idle(3);
        axi_reset = 1'b0;
        idle(2);
        check(m_axis_tvalid == 1'b0, "post_rst_mvalid", m_axis_tvalid, 0);

        // 3-beat pass at full rate
        o0 = outs; p0 = mdl_pass;
        send_pkt(3, 16'h7FFF, 0);
        idle(3);
        check(outs - o0 == 3, "t1_beats_out", outs - o0, 3);
        check(mdl_pass - p0 == 1, "t1_pass_inc", mdl_pass - p0, 1);

        // 4-beat drop
        o0 = outs; d0 = mdl_drop;
        send_pkt(4, 16'h8001, 0);
        idle(3);
        check(outs - o0 == 0, "t2_beats_out", outs - o0, 0);
        check(mdl_drop - d0 == 1, "t2_drop_inc", mdl_drop - d0, 1);

        // alternating single-beat packets with random backpressure
        rdy_rand = 1;
        o0 = outs; p0 = mdl_pass; d0 = mdl_drop;
`ifdef NF10_ENTROPY_FILTER_STATS_EN
        p0 = pkt_pass_cnt; d0 = pkt_drop_cnt;
`endif
        for (int k = 0; k < 10; k++) send_pkt(1, (k % 2 == 0) ? 16'h0000 : 16'hFFFF, 0);
        rdy_rand = 0;
        idle(3);
        check(outs - o0 == 5, "t3_beats_out", outs - o0, 5);
`ifdef NF10_ENTROPY_FILTER_STATS_EN
        check(pkt_pass_cnt - p0 == 5, "t3_pass_cnt", pkt_pass_cnt - p0, 5);
        check(pkt_drop_cnt - d0 == 5, "t3_drop_cnt", pkt_drop_cnt - d0, 5);
`else
        check(mdl_pass - p0 == 5, "t3_pass_mdl", mdl_pass - p0, 5);
        check(mdl_drop - d0 == 5, "t3_drop_mdl", mdl_drop - d0, 5);
`endif

        // threshold lowered mid-packet
        threshold = 16'hFFFF;
        o0 = outs;
        send_beat(16'hFFFF, 0);
        threshold = 16'h0000;
        for (int b = 1; b < 5; b++) send_beat(16'hFFFF, b == 4);
        idle(2);
        check(outs - o0 == 5, "t4_beats_out", outs - o0, 5);
        o0 = outs; d0 = mdl_drop;
        send_pkt(2, 16'h0001, 0);
        idle(2);
        check(outs - o0 == 0, "t4_next_dropped", outs - o0, 0);
        check(mdl_drop - d0 == 1, "t4_drop_inc", mdl_drop - d0, 1);

        // reset in the middle of a passing packet
        threshold = 16'h8000;
        m_axis_tready = 1'b0;
        rdy_rand = 1;
        send_beat(16'h0010, 0);
        send_beat(16'h0010, 0);
        axi_reset = 1'b1;
        #1;
        check(m_axis_tvalid == 1'b0, "t5_async_flush", m_axis_tvalid, 0);
        check(pkt_pass_cnt == 0, "t5_cnt_zero", pkt_pass_cnt, 0);
        idle(2);
        axi_reset = 1'b0;
        rdy_rand = 0;
        idle(1);
        o0 = outs;
        send_pkt(2, 16'h9000, 0);
        send_pkt(2, 16'h1000, 0);
        idle(3);
        check(outs - o0 == 2, "t5_after_rst", outs - o0, 2);

`ifdef NF10_ENTROPY_FILTER_STATS_EN
        force dut.drop_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.drop_cnt_q;
        mdl_drop = 32'hFFFF_FFFF;
        idle(1);
        send_pkt(1, 16'hF000, 0);
        idle(1);
        check(pkt_drop_cnt == 0, "t6_drop_wrap", pkt_drop_cnt, 0);
        clear_cnt = 1'b1;
        send_beat(16'h0001, 1);
        clear_cnt = 1'b0;
        idle(2);
        check(pkt_pass_cnt == 0, "t6_clear_prio", pkt_pass_cnt, 0);
`endif

        // randomized traffic
        rdy_rand = 1;
        for (int p = 0; p < 150; p++) begin
            filter_en = ($urandom_range(0, 3) != 0);
            threshold = 16'($urandom);
            clear_cnt = ($urandom_range(0, 19) == 0);
            send_beat($urandom_range(0, 1) ? 16'($urandom) : threshold + 16'($urandom_range(0, 2)) - 16'd1,
                      $urandom_range(0, 3) == 0);
            clear_cnt = 1'b0;
            if (s_axis_tlast == 1'b0) begin
                int nb = $urandom_range(1, 5);
                for (int b = 0; b < nb; b++) begin
                    if ($urandom_range(0, 3) == 0) threshold = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) filter_en = ~filter_en;
                    send_beat(16'($urandom), b == nb - 1);
                    repeat ($urandom_range(0, 1)) @(posedge axi_aclk);
                    #1;
                end
            end
        end
        rdy_rand = 0;
        idle(5);
        check(expq.size() == 0, "drain_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
